note_judge: RTL and testbench
=============================

Name: note_judge

Overview:
Hit-judgement controller for the rhythm game. Accepts one expected 4-lane note pattern at a time from the note scheduler and opens a timed hit window. During the window it compares the player's debounced button vector against the pattern through a 4-bit equality match. It issues hit/miss pulses and maintains score, combo and max-combo for the display logic.

Parameters:
WINDOW_CYC, 16, length of the hit window in clk cycles (valid range 1..255)
SCORE_W, 16, width of the score counter
COMBO_W, 8, width of the combo and max-combo counters
HIT_PTS, 10, points added per hit

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  game running; low forces IDLE
clr_score  input  1  one-cycle pulse; clears score, combo and max_combo
note_valid  input  1  scheduler offers a note
note_pattern  input  4  expected lanes, bit i = lane i
note_ready  output  1  judge can accept a note
btn  input  4  debounced, synchronised button levels
hit  output  1  one-cycle pulse, correct chord
miss  output  1  one-cycle pulse, wrong or late
score  output  SCORE_W  accumulated score, saturating
combo  output  COMBO_W  consecutive hits, saturating
max_combo  output  COMBO_W  highest combo since the last clear
busy  output  1  high in ARMED or RELEASE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, all outputs 0 (including note_ready), internal pattern register 0, timer 0.
- States: IDLE, ARMED, RELEASE.
- IDLE:
  - note_ready = en.
  - Handshake: a note is accepted when note_valid && note_ready are both high on a rising edge. The judge latches the pattern into pat_q and loads timer = WINDOW_CYC-1.
  - If pattern != 0, go to ARMED. If pattern == 0 (rest), stay in IDLE with no pulse and no score change.
  - note_valid may stay high while note_ready is low; no note is lost.
- ARMED (first compare one cycle after accept):
  - match = (btn == pat_q).
  - wrong = |(btn & ~pat_q), i.e. any lane outside the pattern is pressed.
  - Priority within a cycle: wrong, then match, then timeout.
  - wrong: miss pulse, combo cleared, go to RELEASE.
  - match: hit pulse, score += HIT_PTS (saturating at all-ones), combo += 1 (saturating), max_combo = max(max_combo, new combo), go to IDLE if btn == 0, otherwise RELEASE.
  - No decision and timer == 0: miss pulse, combo cleared, go to RELEASE.
  - Otherwise timer decrements by 1.
  - A partial chord (a subset of pat_q) is neither a hit nor wrong; the window keeps running.
- RELEASE: note_ready = 0. Go to IDLE when btn == 0. This prevents a held chord from scoring the next note.
- Output timing: hit, miss and the counter updates are registered. They become visible in the cycle after the deciding compare and the pulse lasts exactly one cycle. hit and miss are never high together.
- en low: synchronous return to IDLE from any state. An in-flight note is dropped with no pulse. score, combo and max_combo are retained. note_ready = 0.
- clr_score: takes effect on the same edge. It overrides a simultaneous hit update: the counters become 0, but the hit pulse is still issued.
- WINDOW_CYC = 1: exactly one compare cycle.

Decomposition:
- Shared package note_judge_pkg holds:
  - the state enumeration (IDLE/ARMED/RELEASE);
  - the lane-count constant (4);
  - the default WINDOW_CYC, HIT_PTS and counter widths, for reuse by the scheduler and display.
- One natural sub-module, lane_match4. It is purely combinational: inputs pat and btn (4 bits each), outputs match (equality) and wrong (extra lane).

Test Plan:
- Reset mid-ARMED (rst_n low for 1 cycle) -> all outputs 0 immediately; after release note_ready = 1 only when en = 1.
- Pattern 4'b0101 accepted, btn = 0101 three cycles later -> hit pulse one cycle after the match, score 0->10, combo 0->1, max_combo 1; RELEASE until btn = 0.
- WINDOW_CYC = 16, pattern 4'b1000, btn held at 0 -> miss pulse on the cycle after the 16th compare, combo reset to 0, score unchanged.
- Pattern 4'b0011, btn = 0001 for two cycles then 0111 -> no pulse during the partial press, then miss on the wrong press; the next note is not accepted until btn = 0.
- Five hits, one miss, then two hits -> combo 5 -> 0 -> 2, max_combo stays 5. Then clr_score coincident with a hit -> score, combo and max_combo = 0, hit pulse still seen.
- note_valid held high with pattern 0000, then 0010 -> the rest note is consumed silently, 0010 is accepted on the next ready cycle; en dropped mid-window -> IDLE, no pulse, score retained.

Source files
------------

// File: rtl/note_judge_pkg.sv
// Shared definitions for the hit-judgement controller and its neighbours
// (note scheduler, score display).
package note_judge_pkg;

    // Number of button lanes / bits in a note pattern
    localparam int unsigned LANES = 4;

    // Hit-window timer width; covers WINDOW_CYC up to 255
    localparam int unsigned TIMER_W = 8;

    // Default configuration, reused by the scheduler and display
    localparam int unsigned DEF_WINDOW_CYC = 16;
    localparam int unsigned DEF_SCORE_W    = 16;
    localparam int unsigned DEF_COMBO_W    = 8;
    localparam int unsigned DEF_HIT_PTS    = 10;

    // Judge FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/lane_match4.sv
// Combinational chord comparator: exact match and extra-lane detection.
module lane_match4
    import note_judge_pkg::*;
(
    input  logic [LANES-1:0] pat,
    input  logic [LANES-1:0] btn,
    output logic             match,
    output logic             wrong
);

    // Exact chord equality, and any pressed lane that is not in the pattern
    always_comb begin
        match = (btn == pat);
        wrong = |(btn & ~pat);
    end

endmodule

// File: rtl/note_judge.sv
// Hit-judgement controller: accepts one note at a time, opens a timed hit
// window, judges the button chord and keeps score / combo / max-combo.
module note_judge
    import note_judge_pkg::*;
#(
    parameter int unsigned WINDOW_CYC = DEF_WINDOW_CYC,
    parameter int unsigned SCORE_W    = DEF_SCORE_W,
    parameter int unsigned COMBO_W    = DEF_COMBO_W,
    parameter int unsigned HIT_PTS    = DEF_HIT_PTS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr_score,
    input  logic               note_valid,
    input  logic [LANES-1:0]   note_pattern,
    output logic               note_ready,
    input  logic [LANES-1:0]   btn,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic               busy
);

    state_e               state_q, state_d;
    logic [LANES-1:0]     pat_q, pat_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [COMBO_W-1:0]   combo_q, combo_d;
    logic [COMBO_W-1:0]   max_q, max_d;
    // Low until the first clock after reset release, so note_ready is 0 in reset
    logic                 live_q;

    logic                 match, wrong;
    logic [SCORE_W:0]     score_sum;
    logic [COMBO_W-1:0]   combo_inc;

    lane_match4 u_match (
        .pat   (pat_q),
        .btn   (btn),
        .match (match),
        .wrong (wrong)
    );

    assign note_ready = live_q && en && (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign score      = score_q;
    assign combo      = combo_q;
    assign max_combo  = max_q;

    // Next-state, judgement and counter update logic
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        timer_d   = timer_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        score_d   = score_q;
        combo_d   = combo_q;
        max_d     = max_q;
        score_sum = {1'b0, score_q} + (SCORE_W + 1)'(HIT_PTS);
        combo_inc = (&combo_q) ? combo_q : combo_q + COMBO_W'(1);

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (note_valid && note_ready) begin
                        pat_d   = note_pattern;
                        timer_d = TIMER_W'(WINDOW_CYC - 1);
                        if (note_pattern != '0) state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (wrong) begin
                        miss_d  = 1'b1;
                        combo_d = '0;
                        state_d = ST_RELEASE;
                    end else if (match) begin
                        hit_d   = 1'b1;
                        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                        combo_d = combo_inc;
                        max_d   = (combo_inc > max_q) ? combo_inc : max_q;
                        state_d = (btn == '0) ? ST_IDLE : ST_RELEASE;
                    end else if (timer_q == '0) begin
                        miss_d  = 1'b1;
                        combo_d = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (btn == '0) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Clear wins over a same-edge hit update; the hit pulse itself survives
        if (clr_score) begin
            score_d = '0;
            combo_d = '0;
            max_d   = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            timer_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            score_q <= '0;
            combo_q <= '0;
            max_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            timer_q <= timer_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            score_q <= score_d;
            combo_q <= combo_d;
            max_q   <= max_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_note_judge.sv
// Testbench for note_judge: directed scenarios plus randomized play checked
// against a behavioural model, on a default instance and a narrow
// WINDOW_CYC=1 / small-counter instance sharing the same stimulus.
module tb_note_judge;
    import note_judge_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, en, clr_score, note_valid;
    logic [3:0] note_pattern, btn;

    logic        rdy0, hit0, miss0, busy0;
    logic [15:0] score0;
    logic [7:0]  combo0, max0;
    logic        rdy1, hit1, miss1, busy1;
    logic [7:0]  score1;
    logic [3:0]  combo1, max1;

    int checks = 0;
    int errors = 0;

    // Behavioural model, one slot per instance
    int   m_win[2]  = '{16, 1};
    int   m_smax[2] = '{65535, 255};
    int   m_cmax[2] = '{255, 15};
    bit   m_live[2], m_inwin[2], m_hold[2], m_hit[2], m_miss[2];
    int   m_left[2], m_score[2], m_combo[2], m_max[2];
    logic [3:0] m_pat[2];

    always #5 clk = ~clk;

    note_judge u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_score(clr_score),
        .note_valid(note_valid), .note_pattern(note_pattern), .note_ready(rdy0),
        .btn(btn), .hit(hit0), .miss(miss0), .score(score0), .combo(combo0),
        .max_combo(max0), .busy(busy0)
    );

    note_judge #(.WINDOW_CYC(1), .SCORE_W(8), .COMBO_W(4), .HIT_PTS(10)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_score(clr_score),
        .note_valid(note_valid), .note_pattern(note_pattern), .note_ready(rdy1),
        .btn(btn), .hit(hit1), .miss(miss1), .score(score1), .combo(combo1),
        .max_combo(max1), .busy(busy1)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic bit m_ready(input int i);
        return m_live[i] && en && !m_inwin[i] && !m_hold[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_live[i] = 0; m_inwin[i] = 0; m_hold[i] = 0; m_hit[i] = 0; m_miss[i] = 0;
            m_left[i] = 0; m_score[i] = 0; m_combo[i] = 0; m_max[i] = 0; m_pat[i] = '0;
        end
    endtask

    // One rising edge of the game rules, from the inputs present before it
    task automatic model_edge(input int i);
        bit rdy;
        rdy = m_ready(i);
        m_hit[i] = 0;
        m_miss[i] = 0;
        if (!en) begin
            m_inwin[i] = 0;
            m_hold[i]  = 0;
        end else if (m_inwin[i]) begin
            if ((btn & ~m_pat[i]) != 4'd0) begin
                m_miss[i] = 1; m_combo[i] = 0; m_inwin[i] = 0; m_hold[i] = 1;
            end else if (btn == m_pat[i]) begin
                m_hit[i]   = 1;
                m_score[i] = (m_score[i] + 10 > m_smax[i]) ? m_smax[i] : m_score[i] + 10;
                m_combo[i] = (m_combo[i] + 1 > m_cmax[i]) ? m_cmax[i] : m_combo[i] + 1;
                if (m_combo[i] > m_max[i]) m_max[i] = m_combo[i];
                m_inwin[i] = 0;
                m_hold[i]  = (btn != 4'd0);
            end else if (m_left[i] == 1) begin
                m_miss[i] = 1; m_combo[i] = 0; m_inwin[i] = 0; m_hold[i] = 1;
            end else begin
                m_left[i]--;
            end
        end else if (m_hold[i]) begin
            if (btn == 4'd0) m_hold[i] = 0;
        end else if (note_valid && rdy) begin
            m_pat[i]   = note_pattern;
            m_left[i]  = m_win[i];
            m_inwin[i] = (note_pattern != 4'd0);
        end
        if (clr_score) begin
            m_score[i] = 0; m_combo[i] = 0; m_max[i] = 0;
        end
        m_live[i] = 1;
    endtask

    task automatic check_outputs();
        check_val("hit0", hit0, m_hit[0]);
        check_val("miss0", miss0, m_miss[0]);
        check_val("score0", score0, m_score[0]);
        check_val("combo0", combo0, m_combo[0]);
        check_val("max0", max0, m_max[0]);
        check_val("busy0", busy0, m_inwin[0] || m_hold[0]);
        check_val("hit1", hit1, m_hit[1]);
        check_val("miss1", miss1, m_miss[1]);
        check_val("score1", score1, m_score[1]);
        check_val("combo1", combo1, m_combo[1]);
        check_val("max1", max1, m_max[1]);
        check_val("busy1", busy1, m_inwin[1] || m_hold[1]);
    endtask

    // Inputs already applied by the caller (just after an edge)
    task automatic step();
        #1;
        check_val("ready0", rdy0, m_ready(0));
        check_val("ready1", rdy1, m_ready(1));
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr_score = 1'b0; note_valid = 1'b0;
        note_pattern = 4'd0; btn = 4'd0;
        model_reset();
        #2;
        check_val("rst_ready", rdy0, 0);
        check_val("rst_score", score0, 0);
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        en = 1'b1;
        step();
        check_val("ready_en", rdy0, 1);

        // Chord 0101 matched on the third compare
        note_valid = 1'b1; note_pattern = 4'b0101;
        step();
        note_valid = 1'b0;
        step();
        step();
        btn = 4'b0101;
        step();
        check_val("hit_pulse", hit0, 1);
        check_val("hit_score", score0, 10);
        check_val("hit_combo", combo0, 1);
        check_val("hit_max", max0, 1);
        step();
        check_val("hit_once", hit0, 0);
        check_val("held_busy", busy0, 1);
        btn = 4'b0000;
        step();
        check_val("released", busy0, 0);

        // Timeout on pattern 1000 with no press: miss after the 16th compare
        note_valid = 1'b1; note_pattern = 4'b1000;
        step();
        note_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            check_val("no_early_miss", miss0, 0);
        end
        step();
        check_val("timeout_miss", miss0, 1);
        check_val("timeout_combo", combo0, 0);
        check_val("timeout_score", score0, 10);

        // Reset while a note is armed
        step();
        note_valid = 1'b1; note_pattern = 4'b0011;
        step();
        note_valid = 1'b0;
        step();
        check_val("armed_busy", busy0, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("midrst_busy", busy0, 0);
        check_val("midrst_score", score0, 0);
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        en = 1'b0;
        step();
        step();
        check_val("rst_en_low", rdy0, 0);
        en = 1'b1;
        #1;
        check_val("rst_en_high", rdy0, 1);

        // Randomized play
        for (int c = 0; c < 4000; c++) begin
            en         = ($urandom_range(0, 59) != 0);
            clr_score  = ($urandom_range(0, 199) == 0);
            note_valid = ($urandom_range(0, 2) != 0);
            note_pattern = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 6))
                    0, 1, 2: btn = m_pat[0];
                    3:       btn = m_pat[0] & 4'($urandom_range(0, 15));
                    4:       btn = 4'($urandom_range(0, 15));
                    default: btn = 4'd0;
                endcase
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
